// File: rtl/bv_match_encoder_if.sv
// Bundle of handshake and data signals around bv_match_encoder.
//   bv_in_valid/bv_in/bv_in_sop/bv_in_ready : 36-bit AND-reduced chunk stream in
//   match_valid/match_ready/match_hit/match_index : encoded rule result out
// slave = encoder side, master = chunk producer / result consumer side.
interface bv_match_encoder_if #(
  parameter int unsigned CHUNK_W = 36,
  parameter int unsigned IDX_W   = 9
);
  logic               bv_in_valid;
  logic [CHUNK_W-1:0] bv_in;
  logic               bv_in_sop;
  logic               bv_in_ready;
  logic               match_valid;
  logic               match_ready;
  logic               match_hit;
  logic [IDX_W-1:0]   match_index;

  modport slave (
    input  bv_in_valid, bv_in, bv_in_sop, match_ready,
    output bv_in_ready, match_valid, match_hit, match_index
  );

  modport master (
    output bv_in_valid, bv_in, bv_in_sop, match_ready,
    input  bv_in_ready, match_valid, match_hit, match_index
  );
endinterface

// File: rtl/bv_match_encoder.sv
// Collects NUM_CHUNKS chunks of a rule-match bit vector and priority-encodes
// the lowest set rule index into a registered valid/ready result.
//   clk          : clock
//   reset        : asynchronous active-low reset
//   bus          : chunk stream in, match result out (slave modport)
//   sync_err_cnt : saturating count of framing errors (stray sop / missing sop)
module bv_match_encoder #(
  parameter int unsigned CHUNK_W    = 36,
  parameter int unsigned NUM_CHUNKS = 8,
  parameter int unsigned IDX_W      = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  bv_match_encoder_if.slave     bus,
  output logic [15:0]           sync_err_cnt
);

  localparam int unsigned CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned LSB_W = (CHUNK_W > 1) ? $clog2(CHUNK_W) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found_q, found_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mvalid_q, mvalid_d;
  logic               mhit_q, mhit_d;
  logic [IDX_W-1:0]   midx_q, midx_d;
  logic [15:0]        err_q, err_d;

  logic [LSB_W-1:0]   lsb_c;
  logic               chunk_any_c;
  logic               accept_c;
  logic               err_inc_c;
  logic               last_c;
  logic               acc_found_c;
  logic [IDX_W-1:0]   acc_idx_c;

  // A held, unconsumed result backpressures the chunk stream.
  assign bus.bv_in_ready = !(mvalid_q && !bus.match_ready);
  assign accept_c        = bus.bv_in_valid && bus.bv_in_ready;
  assign chunk_any_c     = |bus.bv_in;

  // Lowest set bit of the current chunk; scanning downwards lets the lowest win.
  always_comb begin
    lsb_c = '0;
    for (int i = int'(CHUNK_W) - 1; i >= 0; i--) begin
      if (bus.bv_in[i]) lsb_c = LSB_W'(i);
    end
  end

  // Next-state for accumulator, framing and result register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    found_d     = found_q;
    idx_d       = idx_q;
    mvalid_d    = mvalid_q;
    mhit_d      = mhit_q;
    midx_d      = midx_q;
    err_d       = err_q;
    err_inc_c   = 1'b0;
    last_c      = 1'b0;
    acc_found_c = found_q;
    acc_idx_c   = idx_q;

    // Result drains on handshake; a completing vector below overrides this.
    if (mvalid_q && bus.match_ready) begin
      mvalid_d = 1'b0;
      mhit_d   = 1'b0;
      midx_d   = '0;
    end

    if (accept_c) begin
      if (bus.bv_in_sop) begin
        // Stray sop mid-vector: partial vector is abandoned, chunk restarts it.
        err_inc_c   = (state_q == ACC);
        acc_found_c = chunk_any_c;
        acc_idx_c   = chunk_any_c ? IDX_W'(lsb_c) : '0;
        last_c      = (NUM_CHUNKS == 1);
        cnt_d       = CNT_W'(1);
        state_d     = ACC;
      end else if (state_q == IDLE) begin
        // Missing sop: chunk dropped.
        err_inc_c = 1'b1;
      end else begin
        if (!found_q && chunk_any_c) begin
          acc_found_c = 1'b1;
          acc_idx_c   = IDX_W'(IDX_W'(cnt_q) * IDX_W'(CHUNK_W) + IDX_W'(lsb_c));
        end
        last_c = (cnt_q == CNT_W'(NUM_CHUNKS - 1));
        cnt_d  = cnt_q + CNT_W'(1);
      end

      if (state_q == ACC || bus.bv_in_sop) begin
        found_d = acc_found_c;
        idx_d   = acc_idx_c;
      end

      if (last_c) begin
        mvalid_d = 1'b1;
        mhit_d   = acc_found_c;
        midx_d   = acc_found_c ? acc_idx_c : '0;
        cnt_d    = '0;
        found_d  = 1'b0;
        idx_d    = '0;
        state_d  = IDLE;
      end
    end

    if (err_inc_c && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      idx_q    <= '0;
      mvalid_q <= 1'b0;
      mhit_q   <= 1'b0;
      midx_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
      idx_q    <= idx_d;
      mvalid_q <= mvalid_d;
      mhit_q   <= mhit_d;
      midx_q   <= midx_d;
      err_q    <= err_d;
    end
  end

  assign bus.match_valid = mvalid_q;
  assign bus.match_hit   = mhit_q;
  assign bus.match_index = midx_q;
  assign sync_err_cnt    = err_q;

endmodule

// File: tb/tb_bv_match_encoder.sv
// Directed, table-driven bench for bv_match_encoder.
module tb_bv_match_encoder;

  localparam int unsigned CHUNK_W    = 36;
  localparam int unsigned NUM_CHUNKS = 8;
  localparam int unsigned IDX_W      = 9;

  typedef struct packed {
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] chunks;
    logic                               hit;
    logic [IDX_W-1:0]                   idx;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] sync_err_cnt;
  int          checks;
  int          failures;
  int          cyc;

  logic [IDX_W-1:0] res_idx_q[$];
  logic             res_hit_q[$];
  int               res_cyc_q[$];

  bv_match_encoder_if #(.CHUNK_W(CHUNK_W), .IDX_W(IDX_W)) bus ();

  bv_match_encoder #(
    .CHUNK_W   (CHUNK_W),
    .NUM_CHUNKS(NUM_CHUNKS),
    .IDX_W     (IDX_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .sync_err_cnt(sync_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change at posedge+1, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (reset && bus.match_valid && bus.match_ready) begin
      res_hit_q.push_back(bus.match_hit);
      res_idx_q.push_back(bus.match_index);
      res_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  // Offer one chunk and return one cycle after it is accepted.
  task automatic send(input logic [CHUNK_W-1:0] d, input logic sop);
    bit ok;
    bus.bv_in_valid = 1'b1;
    bus.bv_in       = d;
    bus.bv_in_sop   = sop;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.bv_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("send_ready");
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.bv_in_valid = 1'b0;
    bus.bv_in_sop   = 1'b0;
    bus.bv_in       = '0;
  endtask

  task automatic send_vec(input vec_t v);
    for (int k = 0; k < int'(NUM_CHUNKS); k++) send(v.chunks[k], k == 0);
    idle_in();
  endtask

  task automatic expect_result(input string name, input logic hit, input logic [IDX_W-1:0] idx);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (res_hit_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      timeout_fail(name);
    end else begin
      check({name, "_hit"}, 32'(res_hit_q.pop_front()), 32'(hit));
      check({name, "_idx"}, 32'(res_idx_q.pop_front()), 32'(idx));
      void'(res_cyc_q.pop_front());
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t tbl[6];
  vec_t v;
  int   t0;
  int   c0;
  int   c1;
  int   c2;

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    reset    = 1'b0;
    bus.match_ready = 1'b1;
    idle_in();

    // name-free table: chunks, expected hit, expected index
    for (int i = 0; i < 6; i++) tbl[i] = '0;
    tbl[0].chunks[2] = 36'h0_0000_0010; tbl[0].hit = 1'b1; tbl[0].idx = 9'd76;
    tbl[1].chunks[0] = 36'h8_0000_0000; tbl[1].chunks[7] = 36'h0_0000_0001;
    tbl[1].hit = 1'b1; tbl[1].idx = 9'd35;
    tbl[2].hit = 1'b0; tbl[2].idx = 9'd0;
    tbl[3].chunks[3] = 36'h0_0000_0220; tbl[3].hit = 1'b1; tbl[3].idx = 9'd113;
    tbl[4].chunks[7] = 36'h8_0000_0000; tbl[4].hit = 1'b1; tbl[4].idx = 9'd287;
    tbl[5].chunks[0] = 36'h0_0000_0001; tbl[5].chunks[4] = 36'hF_FFFF_FFFF;
    tbl[5].hit = 1'b1; tbl[5].idx = 9'd0;

    // Reset values
    #12;
    check("rst_ready", 32'(bus.bv_in_ready), 32'd1);
    check("rst_valid", 32'(bus.match_valid), 32'd0);
    check("rst_hit",   32'(bus.match_hit),   32'd0);
    check("rst_index", 32'(bus.match_index), 32'd0);
    check("rst_err",   32'(sync_err_cnt),    32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    cycles(1);

    // Basic encode across the table, 1-cycle latency checked on the first one
    for (int i = 0; i < 6; i++) begin
      send_vec(tbl[i]);
      if (i == 0) check("latency_valid", 32'(bus.match_valid), 32'd1);
      expect_result($sformatf("tbl%0d", i), tbl[i].hit, tbl[i].idx);
    end
    cycles(1);
    check("drained_valid", 32'(bus.match_valid), 32'd0);

    // Stall: result held, next chunk not consumed, then drain and resume
    bus.match_ready = 1'b0;
    v = '0; v.chunks[0] = 36'h0_0000_0008;
    send_vec(v);
    bus.bv_in_valid = 1'b1; bus.bv_in_sop = 1'b1; bus.bv_in = '0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("stall_ready", 32'(bus.bv_in_ready), 32'd0);
      check("stall_idx",   32'(bus.match_index), 32'd3);
    end
    @(posedge clk); #1;
    bus.match_ready = 1'b1;
    send('0, 1'b1);
    for (int k = 1; k < int'(NUM_CHUNKS); k++) send((k == 7) ? 36'h8_0000_0000 : 36'h0, 1'b0);
    idle_in();
    expect_result("stall_first", 1'b1, 9'd3);
    expect_result("stall_second", 1'b1, 9'd287);
    check("stall_err", 32'(sync_err_cnt), 32'd0);

    // Stray sop on the 4th chunk restarts the vector
    send(36'h0, 1'b1);
    send(36'h1, 1'b0);
    send(36'h0, 1'b0);
    v = '0; v.chunks[6] = 36'h0_0000_0002;
    send_vec(v);
    expect_result("resync", 1'b1, 9'd217);
    check("resync_err", 32'(sync_err_cnt), 32'd1);

    // Missing sop in IDLE: chunk dropped, no result
    send(36'h0_0000_00FF, 1'b0);
    idle_in();
    cycles(3);
    check("nosop_err", 32'(sync_err_cnt), 32'd2);
    check("nosop_nores", 32'(res_hit_q.size()), 32'd0);

    // Reset mid-vector discards partial state and the error count
    send(36'h0, 1'b1);
    send(36'h1, 1'b0);
    send(36'h0, 1'b0);
    send(36'h0, 1'b0);
    idle_in();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(bus.bv_in_ready), 32'd1);
    check("midrst_valid", 32'(bus.match_valid), 32'd0);
    check("midrst_err",   32'(sync_err_cnt),    32'd0);
    @(posedge clk); #1 reset = 1'b1;
    cycles(1);
    v = '0; v.chunks[5] = 36'h0_0000_0010;
    send_vec(v);
    expect_result("postrst", 1'b1, 9'd184);
    check("postrst_err", 32'(sync_err_cnt), 32'd0);

    // Back-to-back vectors with continuous valid
    cycles(2);
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < int'(NUM_CHUNKS); k++) send(tbl[i].chunks[k], k == 0);
    end
    idle_in();
    check("b2b_no_bubble", 32'(cyc - t0), 32'd24);
    cycles(2);
    if (res_cyc_q.size() != 3) begin
      check("b2b_count", 32'(res_cyc_q.size()), 32'd3);
    end else begin
      c0 = res_cyc_q[0]; c1 = res_cyc_q[1]; c2 = res_cyc_q[2];
      check("b2b_gap1", 32'(c1 - c0), 32'd8);
      check("b2b_gap2", 32'(c2 - c1), 32'd8);
      for (int i = 0; i < 3; i++) expect_result($sformatf("b2b%0d", i), tbl[i].hit, tbl[i].idx);
    end
    check("b2b_err", 32'(sync_err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
